fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, addresses the zero-latency instruction memory and
// queues {word, pc} pairs in an in-order prefetch buffer offered to decode via valid/ready.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     fetch_en,
   input  logic                     redirect_valid,
   input  logic [31:0]              redirect_pc,
   output logic [31:0]              imem_addr,
   input  logic [31:0]              imem_rd,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic [31:0]              instr,
   output logic [31:0]              instr_pc,
   output logic [31:0]              instr_pc8,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [31:0]   r_pc;
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic          r_valid;
   logic [31:0]   r_head_instr;
   logic [31:0]   r_head_pc;
   logic [31:0]   r_head_pc8;
   logic [31:0]   r_mem_instr [DEPTH];
   logic [31:0]   r_mem_pc    [DEPTH];

   logic          w_pop;
   logic          w_push;
   logic [31:0]   w_pc_nxt;
   logic [AW-1:0] w_rd_ptr_nxt;
   logic [AW-1:0] w_wr_ptr_nxt;
   logic [CW-1:0] w_count_nxt;
   logic [31:0]   w_head_instr;
   logic [31:0]   w_head_pc;

   assign w_pop  = r_valid & instr_ready;
   assign w_push = fetch_en & ~redirect_valid & ((r_count < CW'(DEPTH)) | w_pop);

   // Next PC / pointer / occupancy; a redirect discards the buffer and any same-cycle pop.
   always_comb begin
      w_pc_nxt     = r_pc;
      w_rd_ptr_nxt = r_rd_ptr;
      w_wr_ptr_nxt = r_wr_ptr;
      w_count_nxt  = r_count;
      if (redirect_valid) begin
         w_pc_nxt     = redirect_pc & 32'hFFFF_FFFC;
         w_rd_ptr_nxt = '0;
         w_wr_ptr_nxt = '0;
         w_count_nxt  = '0;
      end else begin
         if (w_push) begin
            w_pc_nxt     = r_pc + 32'd4;
            w_wr_ptr_nxt = r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
         endcase
      end
   end

   // Entry that becomes the head after this edge; bypass when it is the word being written now.
   always_comb begin
      w_head_instr = r_mem_instr[w_rd_ptr_nxt];
      w_head_pc    = r_mem_pc[w_rd_ptr_nxt];
      if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
         w_head_instr = imem_rd;
         w_head_pc    = r_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pc         <= RESET_PC;
         r_rd_ptr     <= '0;
         r_wr_ptr     <= '0;
         r_count      <= '0;
         r_valid      <= 1'b0;
         r_head_instr <= '0;
         r_head_pc    <= '0;
         r_head_pc8   <= '0;
      end else begin
         r_pc     <= w_pc_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_wr_ptr <= w_wr_ptr_nxt;
         r_count  <= w_count_nxt;
         r_valid  <= (w_count_nxt != '0);
         // Head registers hold their last contents while the buffer is empty.
         if (w_count_nxt != '0) begin
            r_head_instr <= w_head_instr;
            r_head_pc    <= w_head_pc;
            r_head_pc8   <= w_head_pc + 32'd8;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n && w_push) begin
         r_mem_instr[r_wr_ptr] <= imem_rd;
         r_mem_pc[r_wr_ptr]    <= r_pc;
      end
   end

   assign imem_addr   = r_pc;
   assign instr_valid = r_valid;
   assign instr       = r_head_instr;
   assign instr_pc    = r_head_pc;
   assign instr_pc8   = r_head_pc8;
   assign fifo_count  = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: hand-derived vector table for the directed scenarios, backed by a
// reference queue model that scores every pop and every post-edge output, then random traffic.
module tb_fetch_unit;

   localparam int unsigned DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_rd;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc8;
   logic [1:0]  fifo_count;

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_addr(imem_addr), .imem_rd(imem_rd),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc), .instr_pc8(instr_pc8),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hE000_0000 + {2'b00, a[31:2]};
   endfunction

   assign imem_rd = mem_word(imem_addr);

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   typedef struct {
      logic        rn, fe, rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        ev;
      logic [31:0] ecnt;
      logic [31:0] eaddr;
      logic [31:0] einstr, epc, epc8;
      logic        chk_head;
   } vec_t;

   entry_t      q[$];
   logic [31:0] m_pc, m_instr, m_ipc, m_ipc8;
   int          n_chk  = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, score any pop against the queue, advance the model, check after edge.
   task automatic cycle(input logic rn, input logic fe, input logic rv,
                        input logic [31:0] rpc, input logic rdy);
      logic pop, push;
      int   sz;
      reset_n = rn; fetch_en = fe; redirect_valid = rv; redirect_pc = rpc; instr_ready = rdy;
      #1;
      sz  = q.size();
      pop = (sz != 0) && rdy;
      if (pop) begin
         chk("pop_instr", instr, q[0].instr);
         chk("pop_pc", instr_pc, q[0].pc);
      end
      if (!rn) begin
         q.delete();
         m_pc = RESET_PC; m_instr = '0; m_ipc = '0; m_ipc8 = '0;
      end else if (rv) begin
         q.delete();
         m_pc = {rpc[31:2], 2'b00};
      end else begin
         push = fe && ((sz < DEPTH) || pop);
         if (pop) void'(q.pop_front());
         if (push) begin
            q.push_back('{instr: mem_word(m_pc), pc: m_pc});
            m_pc = m_pc + 32'd4;
         end
      end
      if (rn && q.size() != 0) begin
         m_instr = q[0].instr; m_ipc = q[0].pc; m_ipc8 = q[0].pc + 32'd8;
      end
      @(posedge clk); #1;
      chk("valid", 32'(instr_valid), 32'(q.size() != 0));
      chk("count", 32'(fifo_count), 32'(q.size()));
      chk("imem_addr", imem_addr, m_pc);
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_ipc);
      chk("instr_pc8", instr_pc8, m_ipc8);
   endtask

   function automatic vec_t mk(input logic rn, input logic fe, input logic rv,
                               input logic [31:0] rpc, input logic rdy, input logic ev,
                               input logic [31:0] ecnt, input logic [31:0] ea,
                               input logic [31:0] ei, input logic [31:0] ep,
                               input logic [31:0] ep8, input logic ch);
      vec_t v;
      v.rn = rn; v.fe = fe; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev;
      v.ecnt = ecnt; v.eaddr = ea; v.einstr = ei; v.epc = ep; v.epc8 = ep8; v.chk_head = ch;
      return v;
   endfunction

   vec_t vt[18];

   initial begin
      // rn fe rv rpc rdy | valid cnt addr instr pc pc8 chk_head
      vt[0]  = mk(1'b1,1'b1,1'b0,32'h0,1'b0, 1'b1,32'd1,32'h04, 32'hE000_0000,32'h00,32'h08,1'b1);
      vt[1]  = mk(1'b1,1'b1,1'b0,32'h0,1'b0, 1'b1,32'd2,32'h08, 32'hE000_0000,32'h00,32'h08,1'b1);
      vt[2]  = mk(1'b1,1'b1,1'b0,32'h0,1'b0, 1'b1,32'd2,32'h08, 32'hE000_0000,32'h00,32'h08,1'b1);
      vt[3]  = mk(1'b1,1'b1,1'b0,32'h0,1'b1, 1'b1,32'd2,32'h0C, 32'hE000_0001,32'h04,32'h0C,1'b1);
      vt[4]  = mk(1'b1,1'b1,1'b0,32'h0,1'b1, 1'b1,32'd2,32'h10, 32'hE000_0002,32'h08,32'h10,1'b1);
      vt[5]  = mk(1'b1,1'b1,1'b0,32'h0,1'b1, 1'b1,32'd2,32'h14, 32'hE000_0003,32'h0C,32'h14,1'b1);
      vt[6]  = mk(1'b1,1'b1,1'b1,32'h23,1'b1,1'b0,32'd0,32'h20, 32'h0,32'h0,32'h0,1'b0);
      vt[7]  = mk(1'b1,1'b1,1'b0,32'h0,1'b0, 1'b1,32'd1,32'h24, 32'hE000_0008,32'h20,32'h28,1'b1);
      vt[8]  = mk(1'b1,1'b1,1'b0,32'h0,1'b0, 1'b1,32'd2,32'h28, 32'hE000_0008,32'h20,32'h28,1'b1);
      vt[9]  = mk(1'b1,1'b0,1'b0,32'h0,1'b1, 1'b1,32'd1,32'h28, 32'hE000_0009,32'h24,32'h2C,1'b1);
      vt[10] = mk(1'b1,1'b0,1'b0,32'h0,1'b1, 1'b0,32'd0,32'h28, 32'hE000_0009,32'h24,32'h2C,1'b1);
      vt[11] = mk(1'b1,1'b0,1'b0,32'h0,1'b0, 1'b0,32'd0,32'h28, 32'hE000_0009,32'h24,32'h2C,1'b1);
      vt[12] = mk(1'b1,1'b1,1'b1,32'hFFFF_FFFC,1'b0, 1'b0,32'd0,32'hFFFF_FFFC, 32'h0,32'h0,32'h0,1'b0);
      vt[13] = mk(1'b1,1'b1,1'b0,32'h0,1'b0, 1'b1,32'd1,32'h00, 32'h1FFF_FFFF,32'hFFFF_FFFC,32'h04,1'b1);
      vt[14] = mk(1'b1,1'b1,1'b0,32'h0,1'b1, 1'b1,32'd1,32'h04, 32'hE000_0000,32'h00,32'h08,1'b1);
      vt[15] = mk(1'b1,1'b1,1'b0,32'h0,1'b0, 1'b1,32'd2,32'h08, 32'hE000_0000,32'h00,32'h08,1'b1);
      vt[16] = mk(1'b0,1'b1,1'b1,32'h100,1'b1,1'b0,32'd0,32'h00, 32'h0,32'h0,32'h0,1'b1);
      vt[17] = mk(1'b1,1'b1,1'b0,32'h0,1'b0, 1'b1,32'd1,32'h04, 32'hE000_0000,32'h00,32'h08,1'b1);

      reset_n = 1'b0; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
      m_pc = RESET_PC; m_instr = '0; m_ipc = '0; m_ipc8 = '0;
      @(posedge clk); #1;
      cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_addr", imem_addr, RESET_PC);
      chk("rst_instr", instr, 32'd0);
      chk("rst_pc8", instr_pc8, 32'd0);

      for (int i = 0; i < 18; i++) begin
         cycle(vt[i].rn, vt[i].fe, vt[i].rv, vt[i].rpc, vt[i].rdy);
         chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vt[i].ev));
         chk($sformatf("vec%0d_count", i), 32'(fifo_count), vt[i].ecnt);
         chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].eaddr);
         if (vt[i].chk_head) begin
            chk($sformatf("vec%0d_instr", i), instr, vt[i].einstr);
            chk($sformatf("vec%0d_pc", i), instr_pc, vt[i].epc);
            chk($sformatf("vec%0d_pc8", i), instr_pc8, vt[i].epc8);
         end
      end

      // Long back-to-back stream from a full buffer: no gaps, no duplicates.
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
         chk("stream_count", 32'(fifo_count), 32'd2);
      end

      // Random traffic scored by the model.
      for (int i = 0; i < 500; i++) begin
         cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 15) == 0), $urandom, 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
